// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, op encodings and FSM states for the shift arbiter slice.
package shift_pkg;
  localparam int WIDTH = 16;
  localparam int AMT_W = 4;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_t;
endpackage

// File: rtl/barrel_core16.sv
// barrel_core16: combinational 16-bit shifter built from four log stages (1, 2, 4, 8).
module barrel_core16
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0]   stage [AMT_W+1];
  logic [WIDTH/2-1:0] fill;
  assign fill = {(WIDTH/2){op == OP_SRA && data[WIDTH-1]}};
  assign stage[0] = data;
  for (genvar i = 0; i < AMT_W; i++) begin : g_stage
    localparam int K = 1 << i;
    logic [WIDTH-1:0] left, right;
    assign left = {stage[i][WIDTH-1-K:0], {K{1'b0}}};
    // right shifts share one path; ROR wraps the low bits back in instead of fill
    assign right = {op == OP_ROR ? stage[i][K-1:0] : fill[K-1:0], stage[i][WIDTH-1:K]};
    assign stage[i+1] = !amt[i] ? stage[i] : op == OP_SLL ? left : right;
  end
  assign result = stage[AMT_W];
endmodule

// File: rtl/shift_req_arbiter.sv
// shift_req_arbiter: round-robin arbiter for two requesters sharing one barrel shifter,
// sequenced IDLE -> EXEC -> HOLD with a registered valid/ready result port.
module shift_req_arbiter
  import shift_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [1:0]       req1_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] opd_data_q, opd_data_d;
  logic [AMT_W-1:0] opd_amt_q, opd_amt_d;
  logic [1:0]       opd_op_q, opd_op_d;
  logic             opd_id_q, opd_id_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle, grant0, grant1;
  logic [WIDTH-1:0] result;
  barrel_core16 u_core (.data(opd_data_q), .amt(opd_amt_q), .op(opd_op_q), .result(result));
  // last_q=1 after reset makes requester 0 win the first tie
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && !grant0;
  assign idle = state_q == ST_IDLE && !reset;
  assign req0_ready = idle && grant0;
  assign req1_ready = idle && grant1;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_id = out_id_q;
  assign busy = state_q != ST_IDLE;
  assign done_cnt = cnt_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    opd_data_d = opd_data_q;
    opd_amt_d = opd_amt_q;
    opd_op_d = opd_op_q;
    opd_id_d = opd_id_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_id_d = out_id_q;
    cnt_d = cnt_q;
    if (req0_ready || req1_ready) begin
      state_d = ST_EXEC;
      last_d = req1_ready;
      opd_data_d = req1_ready ? req1_data : req0_data;
      opd_amt_d = req1_ready ? req1_amt : req0_amt;
      opd_op_d = req1_ready ? req1_op : req0_op;
      opd_id_d = req1_ready;
    end
    if (state_q == ST_EXEC) begin
      state_d = ST_HOLD;
      out_valid_d = 1'b1;
      out_data_d = result;
      out_id_d = opd_id_q;
    end
    if (state_q == ST_HOLD && out_ready) begin
      state_d = ST_IDLE;
      out_valid_d = 1'b0;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q <= 1'b1;
      opd_data_q <= '0;
      opd_amt_q <= '0;
      opd_op_q <= OP_SLL;
      opd_id_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_id_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      opd_data_q <= opd_data_d;
      opd_amt_q <= opd_amt_d;
      opd_op_q <= opd_op_d;
      opd_id_q <= opd_id_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_id_q <= out_id_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
